uart_tx_core: RTL and testbench
===============================

UART_TX_CORE -- requirements
Module: uart_tx_core

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset. Ports SHALL be CLK and RST.
REQ-002 CLK  input  1  system clock; all state changes on the rising edge.
REQ-003 RST  input  1  asynchronous active-high reset.
REQ-004 P_DATA  input  8  parallel byte to transmit; sampled only on acceptance.
REQ-005 DATA_VALID  input  1  request to send P_DATA; single-cycle or held.
REQ-006 PAR_EN  input  1  1 = append a parity bit; sampled on acceptance.
REQ-007 PAR_TYP  input  1  0 = even parity, 1 = odd parity; sampled on acceptance.
REQ-008 prescale  input  6  CLK cycles per serial bit; sampled on acceptance; a value of 0 SHALL be treated as 1.
REQ-009 TX_OUT  output  1  registered serial line; LSB-first UART frame; idles high.
REQ-010 busy  output  1  registered; high while a frame is in flight.

Function
REQ-011 FSM states SHALL be IDLE, START, DATA, PARITY and STOP.
REQ-012 Acceptance SHALL occur on a rising edge where state = IDLE and DATA_VALID = 1.
REQ-013 On acceptance, the following SHALL happen on that same edge:
- latch P_DATA, PAR_EN, PAR_TYP and prescale;
- drive TX_OUT to 0 and busy to 1;
- enter START.
REQ-014 DATA_VALID SHALL be ignored while busy = 1; latched values SHALL NOT change mid-frame, even if the inputs change.
REQ-015 Each frame bit SHALL hold TX_OUT for exactly the latched prescale CLK cycles, timed by a bit-cycle counter that restarts at every bit boundary.
REQ-016 In DATA, the bits SHALL be driven in the order data[0] through data[7], using a 3-bit index.
- After data[7], the FSM SHALL go to PARITY if the latched PAR_EN = 1, otherwise to STOP.
REQ-017 The parity bit SHALL be:
- even parity: XOR of the 8 data bits;
- odd parity: the inverse of that XOR.
REQ-018 STOP SHALL drive TX_OUT = 1 for prescale cycles.
REQ-019 At the edge that ends the STOP bit, the block SHALL enter IDLE and set busy to 0.
- A new acceptance is possible on the next edge.
- This gives back-to-back frames with no idle gap beyond the stop bit.
REQ-020 Frame length SHALL be 10 x prescale cycles without parity and 11 x prescale cycles with parity, measured from the acceptance edge to the busy-fall edge.
REQ-021 In IDLE, TX_OUT SHALL be 1 and busy SHALL be 0.
REQ-022 TX_OUT SHALL be glitch-free, driven directly from a flop.

Reset
REQ-023 While RST = 1, regardless of the clock:
- TX_OUT = 1 and busy = 0;
- state = IDLE;
- the bit counter, bit index and latched registers = 0.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately with the line high; no partial frame resumes after release.
REQ-025 After RST deasserts, the first acceptance SHALL be possible on the first rising edge.

Verification
REQ-026 prescale = 8, PAR_EN = 0, P_DATA = 0x5A with a 1-cycle pulse: TX_OUT SHALL be 0,0,1,0,1,1,0,1,0,1 with each bit 8 cycles wide; busy SHALL be high for exactly 80 cycles.
REQ-027 prescale = 8, PAR_EN = 1, PAR_TYP = 0, P_DATA = 0x4B: the parity bit SHALL be 0, the frame SHALL be 88 cycles, and a downstream UART RX at prescale 8 SHALL assert data_valid with P_DATA = 0x4B.
REQ-028 prescale = 8, PAR_EN = 1, PAR_TYP = 1, P_DATA = 0x4B: the parity bit SHALL be 1; changing P_DATA and PAR_TYP mid-frame SHALL leave the frame unchanged.
REQ-029 DATA_VALID held high for 0xA5 then 0x3C, prescale = 8, PAR_EN = 0:
- two contiguous frames SHALL be sent;
- busy SHALL go low for exactly 1 cycle between them;
- the stop bit SHALL be 8 cycles.
REQ-030 prescale = 0: each bit SHALL be 1 cycle wide (10-cycle frame).
REQ-031 Reset asserted during data bit 3 at prescale = 8: TX_OUT = 1 and busy = 0 SHALL hold at once and remain so after release until the next DATA_VALID.

Source files
------------

// File: rtl/uart_tx_core.sv
// uart_tx_core
//   Serialises one byte per request as an LSB-first UART frame:
//   start (0), data[0..7], optional parity, stop (1).
//   Every bit is held for the latched prescale count of CLK cycles.
//   A prescale of 0 is treated as 1.
//
// Ports
//   CLK        in   1  system clock; all state changes on the rising edge
//   RST        in   1  asynchronous active-high reset
//   P_DATA     in   8  byte to send; sampled on acceptance
//   DATA_VALID in   1  send request; single-cycle or held; ignored while busy
//   PAR_EN     in   1  1 = append a parity bit; sampled on acceptance
//   PAR_TYP    in   1  0 = even parity, 1 = odd parity; sampled on acceptance
//   prescale   in   6  CLK cycles per serial bit; sampled on acceptance
//   TX_OUT     out  1  serial line, driven from a flop; idles high
//   busy       out  1  registered; high while a frame is in flight
module uart_tx_core (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] P_DATA,
  input  logic       DATA_VALID,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  input  logic [5:0] prescale,
  output logic       TX_OUT,
  output logic       busy
);

  // Encodings kept identical to the legacy localparam values.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t     state;
  logic [5:0] bit_cnt;
  logic [2:0] bit_idx;
  logic [7:0] data_q;
  logic       par_en_q;
  logic       par_typ_q;
  logic [5:0] ps_q;

  logic       bit_done;
  logic [2:0] next_idx;
  logic       par_bit;

  // ps_q is never 0 outside IDLE, so ps_q - 1 cannot wrap mid-frame.
  assign bit_done = (bit_cnt == (ps_q - 6'd1));
  assign next_idx = bit_idx + 3'd1;
  // Even parity is the XOR of the data bits; odd parity inverts it.
  assign par_bit  = (^data_q) ^ par_typ_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      TX_OUT    <= 1'b1;
      busy      <= 1'b0;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      ps_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          TX_OUT  <= 1'b1;
          busy    <= 1'b0;
          bit_cnt <= '0;
          bit_idx <= '0;
          if (DATA_VALID) begin
            // Acceptance edge: latch everything and start the start bit now.
            data_q    <= P_DATA;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
            ps_q      <= (prescale == 6'd0) ? 6'd1 : prescale;
            TX_OUT    <= 1'b0;
            busy      <= 1'b1;
            state     <= START;
          end
        end

        START: begin
          if (bit_done) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            TX_OUT  <= data_q[0];
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt + 6'd1;
          end
        end

        DATA: begin
          if (bit_done) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              if (par_en_q) begin
                TX_OUT <= par_bit;
                state  <= PARITY;
              end else begin
                TX_OUT <= 1'b1;
                state  <= STOP;
              end
            end else begin
              bit_idx <= next_idx;
              TX_OUT  <= data_q[next_idx];
            end
          end else begin
            bit_cnt <= bit_cnt + 6'd1;
          end
        end

        PARITY: begin
          if (bit_done) begin
            bit_cnt <= '0;
            TX_OUT  <= 1'b1;
            state   <= STOP;
          end else begin
            bit_cnt <= bit_cnt + 6'd1;
          end
        end

        STOP: begin
          if (bit_done) begin
            // Back in IDLE on this edge, so a held request is accepted on the next.
            bit_cnt <= '0;
            bit_idx <= '0;
            TX_OUT  <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            bit_cnt <= bit_cnt + 6'd1;
          end
        end

        default: begin
          TX_OUT  <= 1'b1;
          busy    <= 1'b0;
          bit_cnt <= '0;
          bit_idx <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Testbench for uart_tx_core.
// Stimulus pushes hand-computed expected frames into a queue. A monitor
// detects each busy rise, pops one entry and checks every bit period,
// the frame end, the mid-bit-decoded byte and back-to-back spacing.
module tb_uart_tx_core;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA = '0;
  logic       DATA_VALID = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [5:0] prescale = '0;
  logic       TX_OUT;
  logic       busy;

  uart_tx_core dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .prescale   (prescale),
    .TX_OUT     (TX_OUT),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  // bits[i] is the i-th bit on the line (bits[0] = start bit).
  typedef struct {
    logic [10:0] bits;
    int          nbits;
    int          ps;
    logic [7:0]  dat;
    bit          b2b;
    bit          aborted;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cyc     = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name,
                       input int unsigned act, input int unsigned req);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [10:0] bits, input int nbits, input int ps,
                      input logic [7:0] dat, input bit b2b, input bit aborted);
    exp_t e;
    e.bits = bits; e.nbits = nbits; e.ps = ps; e.dat = dat;
    e.b2b = b2b; e.aborted = aborted;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] d, input logic pe, input logic pt,
                      input logic [5:0] ps);
    @(posedge CLK); #1;
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; prescale = ps; DATA_VALID = 1'b1;
    @(posedge CLK); #1;
    DATA_VALID = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 2000) begin
      @(posedge CLK); #1;
      n++;
    end
    if (n >= 2000) check(1'b0, {name, "_idle_timeout"}, n, 2000);
  endtask

  // Monitor / scoreboard
  initial begin : monitor
    exp_t        e;
    logic        prev_busy;
    bit          have_end;
    int unsigned end_cyc;
    bit          aborted;
    bit          bit_ok;
    logic [1:0]  bad;
    logic [10:0] rx_bits;
    int          fr;
    prev_busy = 1'b0;
    have_end  = 1'b0;
    end_cyc   = 0;
    fr        = 0;
    forever begin
      @(negedge CLK);
      if (RST !== 1'b0) begin
        prev_busy = 1'b0;
        have_end  = 1'b0;
        continue;
      end
      if (busy === 1'b1 && prev_busy !== 1'b1) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_frame", 1, 0);
          prev_busy = busy;
          continue;
        end
        e = exp_q.pop_front();
        fr++;
        if (e.b2b)
          check(have_end && (cyc == end_cyc + 1), $sformatf("frame%0d_b2b_gap", fr),
                cyc - end_cyc, 1);
        aborted = 1'b0;
        rx_bits = '0;
        for (int b = 0; b < e.nbits; b++) begin
          bit_ok = 1'b1;
          bad    = {1'b1, e.bits[b]};
          for (int k = 0; k < e.ps; k++) begin
            if (RST !== 1'b0) aborted = 1'b1;
            if (aborted) break;
            if (TX_OUT !== e.bits[b] || busy !== 1'b1) begin
              bit_ok = 1'b0;
              bad    = {busy, TX_OUT};
            end
            if (k == e.ps / 2) rx_bits[b] = TX_OUT;
            @(negedge CLK);
          end
          if (aborted) break;
          check(bit_ok, $sformatf("frame%0d_bit%0d {busy,tx}", fr, b),
                bad, {1'b1, e.bits[b]});
        end
        if (aborted) begin
          check(e.aborted, $sformatf("frame%0d_abort_expected", fr), 1, e.aborted);
          check(TX_OUT === 1'b1 && busy === 1'b0, $sformatf("frame%0d_abort_line {busy,tx}", fr),
                {busy, TX_OUT}, 2'b01);
          prev_busy = 1'b0;
          have_end  = 1'b0;
        end else begin
          if (e.aborted) check(1'b0, $sformatf("frame%0d_abort_missing", fr), 0, 1);
          check(busy === 1'b0 && TX_OUT === 1'b1, $sformatf("frame%0d_end {busy,tx}", fr),
                {busy, TX_OUT}, 2'b01);
          check(rx_bits[8:1] === e.dat, $sformatf("frame%0d_rx_byte", fr),
                rx_bits[8:1], e.dat);
          end_cyc   = cyc;
          have_end  = 1'b1;
          prev_busy = busy;
        end
      end else begin
        prev_busy = busy;
      end
    end
  end

  // Stimulus
  initial begin : stim
    int n;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check(TX_OUT === 1'b1 && busy === 1'b0, "reset_state {busy,tx}", {busy, TX_OUT}, 2'b01);

    // 0x5A, prescale 8, no parity; request issued in the same gap as reset release.
    push(11'b0_1_01011010_0, 10, 8, 8'h5A, 1'b0, 1'b0);
    RST = 1'b0;
    P_DATA = 8'h5A; PAR_EN = 1'b0; PAR_TYP = 1'b0; prescale = 6'd8; DATA_VALID = 1'b1;
    @(posedge CLK); #1;
    DATA_VALID = 1'b0;
    wait_idle("5a");

    // 0x4B even parity: popcount 4 -> parity 0.
    push(11'b1_0_01001011_0, 11, 8, 8'h4B, 1'b0, 1'b0);
    send(8'h4B, 1'b1, 1'b0, 6'd8);
    wait_idle("4b_even");

    // 0x4B odd parity -> 1; inputs scrambled mid-frame must not matter.
    push(11'b1_1_01001011_0, 11, 8, 8'h4B, 1'b0, 1'b0);
    send(8'h4B, 1'b1, 1'b1, 6'd8);
    repeat (5) @(posedge CLK);
    #1;
    P_DATA = 8'hFF; PAR_TYP = 1'b0; PAR_EN = 1'b0; prescale = 6'd2;
    wait_idle("4b_odd");

    // Held request: 0xA5 then 0x3C back to back.
    push(11'b0_1_10100101_0, 10, 8, 8'hA5, 1'b0, 1'b0);
    push(11'b0_1_00111100_0, 10, 8, 8'h3C, 1'b1, 1'b0);
    @(posedge CLK); #1;
    P_DATA = 8'hA5; PAR_EN = 1'b0; PAR_TYP = 1'b0; prescale = 6'd8; DATA_VALID = 1'b1;
    @(posedge CLK); #1;
    P_DATA = 8'h3C;
    wait_idle("a5");
    @(posedge CLK); #1;
    DATA_VALID = 1'b0;
    wait_idle("3c");

    // prescale 0 behaves as 1.
    push(11'b0_1_11000011_0, 10, 1, 8'hC3, 1'b0, 1'b0);
    send(8'hC3, 1'b0, 1'b0, 6'd0);
    wait_idle("ps0");

    // prescale 1, even parity on 0xFF -> 0.
    push(11'b1_0_11111111_0, 11, 1, 8'hFF, 1'b0, 1'b0);
    send(8'hFF, 1'b1, 1'b0, 6'd1);
    wait_idle("ps1_ff");

    // prescale 3, odd parity on 0x01 -> 0.
    push(11'b1_0_00000001_0, 11, 3, 8'h01, 1'b0, 1'b0);
    send(8'h01, 1'b1, 1'b1, 6'd3);
    wait_idle("ps3_01");

    // Reset during data bit 3 (cycles 32..39 after acceptance).
    push(11'b0_1_01011010_0, 10, 8, 8'h5A, 1'b0, 1'b1);
    send(8'h5A, 1'b0, 1'b0, 6'd8);
    repeat (34) @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    check(TX_OUT === 1'b1 && busy === 1'b0, "reset_immediate {busy,tx}", {busy, TX_OUT}, 2'b01);
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK); #1;
      if (TX_OUT !== 1'b1 || busy !== 1'b0) n++;
    end
    check(n == 0, "post_reset_idle bad_cycles", n, 0);

    // Recovery frame after the aborted one.
    push(11'b0_1_00111100_0, 10, 2, 8'h3C, 1'b0, 1'b0);
    send(8'h3C, 1'b0, 1'b0, 6'd2);
    wait_idle("recover");

    repeat (4) @(posedge CLK);
    check(exp_q.size() == 0, "queue_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "time limit");
  end

endmodule
